// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the related
// sequence-detector bench: FSM state type and default geometry.
package seq_pkg;

  localparam int unsigned SEQ_WORD_W = 32;
  localparam int unsigned SEQ_IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/seq_serializer.sv
// Serial pattern generator: captures a word on load and shifts it out LSB
// first, one bit per clock, optionally repeating until stopped. A one-cycle
// done pulse marks normal completion of a non-repeating pattern.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WORD_W = SEQ_WORD_W,
  parameter int unsigned IDX_W  = SEQ_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [IDX_W-1:0]  len,
  input  logic              rpt,
  input  logic              stop,
  output logic              ready,
  output logic              outp,
  output logic              out_valid,
  output logic [IDX_W-1:0]  bit_idx,
  output logic              done
);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   data_q,  data_d;
  logic [IDX_W-1:0]    len_q,   len_d;
  logic                rpt_q,   rpt_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;

  // Next-state logic: capture on accepted load, advance/wrap/finish in SHIFT.
  // stop is tested before the end-of-pattern check so it wins at the last bit.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (load) begin
          data_d  = data;
          len_d   = len;
          rpt_d   = rpt;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) begin
          idx_d   = '0;
          state_d = IDLE;
        end else if (idx_q == len_q) begin
          idx_d = '0;
          if (!rpt_q) begin
            state_d = DONE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      len_q   <= '0;
      rpt_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      len_q   <= len_d;
      rpt_q   <= rpt_d;
      idx_q   <= idx_d;
    end
  end

  // Moore output decode from state and registered index/word only.
  always_comb begin
    ready     = (state_q == IDLE);
    out_valid = (state_q == SHIFT);
    done      = (state_q == DONE);
    bit_idx   = out_valid ? idx_q : '0;
    outp      = out_valid ? data_q[idx_q] : 1'b0;
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed scenarios followed by a
// randomized run, all compared against a cycle-count reference model.
module tb_seq_serializer;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  logic          clk = 1'b0;
  logic          rst, load, rpt, stop;
  logic [W-1:0]  data;
  logic [IW-1:0] len;
  logic          ready, outp, out_valid, done;
  logic [IW-1:0] bit_idx;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: a pattern is either running (with a count of bits sent
  // since acceptance), in its one-cycle completion slot, or absent.
  bit            m_run, m_done, m_rpt;
  logic [W-1:0]  m_data;
  int unsigned   m_len, m_t;

  logic [W-1:0]  word;

  always #5 clk = ~clk;

  seq_serializer #(.WORD_W(W), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .data      (data),
    .len       (len),
    .rpt       (rpt),
    .stop      (stop),
    .ready     (ready),
    .outp      (outp),
    .out_valid (out_valid),
    .bit_idx   (bit_idx),
    .done      (done)
  );

  function automatic int unsigned exp_idx();
    return m_run ? (m_t % (m_len + 1)) : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_run = 0; m_done = 0; m_rpt = 0; m_data = '0; m_len = 0; m_t = 0;
    end else if (m_run) begin
      if (stop) m_run = 0;
      else if (!m_rpt && m_t == m_len) begin
        m_run = 0; m_done = 1;
      end else m_t++;
    end else if (m_done) begin
      m_done = 0;
    end else if (load) begin
      m_run = 1; m_t = 0; m_data = data; m_len = int'(len); m_rpt = rpt;
    end
  endtask

  task automatic compare_all();
    int unsigned ei;
    ei = exp_idx();
    check("ready",     {31'd0, ready},     {31'd0, !m_run && !m_done});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_run});
    check("done",      {31'd0, done},      {31'd0, m_done});
    check("bit_idx",   {27'd0, bit_idx},   ei);
    check("outp",      {31'd0, outp},      {31'd0, m_run ? m_data[ei] : 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1; load = 0; stop = 0; rpt = 0; data = '0; len = '0;
    m_run = 0; m_done = 0; m_rpt = 0; m_data = '0; m_len = 0; m_t = 0;
    word = 32'h38F738F3;
    tick(); tick();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 0;
    tick();

    // Full 32-bit pattern, no repeat
    data = word; len = 5'd31; rpt = 0; load = 1;
    tick();
    load = 0; data = $urandom;
    for (int i = 0; i < 32; i++) begin
      check("r030_bit", {31'd0, outp}, {31'd0, word[i]});
      check("r030_idx", {27'd0, bit_idx}, i);
      tick();
    end
    check("r030_done", {31'd0, done}, 32'd1);
    check("r030_done_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("r030_ready", {31'd0, ready}, 32'd1);
    tick();

    // Repeat mode: seamless wrap, then stop at index 10
    data = word; len = 5'd31; rpt = 1; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 32; i++) begin
      check("r031_bit", {31'd0, outp}, {31'd0, word[i]});
      tick();
    end
    check("r031_wrap_idx", {27'd0, bit_idx}, 32'd0);
    check("r031_wrap_bit", {31'd0, outp}, 32'd1);
    check("r031_wrap_valid", {31'd0, out_valid}, 32'd1);
    check("r031_no_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("r031_idx10", {27'd0, bit_idx}, 32'd10);
    stop = 1;
    tick();
    stop = 0;
    check("r031_stop_ready", {31'd0, ready}, 32'd1);
    check("r031_stop_done", {31'd0, done}, 32'd0);
    tick();
    check("r031_stop_done2", {31'd0, done}, 32'd0);

    // Single-bit pattern, then single-bit repeat
    data = 32'd1; len = 5'd0; rpt = 0; load = 1;
    tick();
    load = 0;
    check("r032_bit", {31'd0, outp}, 32'd1);
    check("r032_valid", {31'd0, out_valid}, 32'd1);
    tick();
    check("r032_done", {31'd0, done}, 32'd1);
    tick();
    check("r032_ready", {31'd0, ready}, 32'd1);
    data = 32'd1; len = 5'd0; rpt = 1; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 4; i++) begin
      check("r023_rep_bit", {31'd0, outp}, 32'd1);
      check("r023_rep_idx", {27'd0, bit_idx}, 32'd0);
      tick();
    end
    stop = 1; tick(); stop = 0;

    // Loads during SHIFT are ignored
    data = word; len = 5'd7; rpt = 0; load = 1;
    tick();
    data = '0; len = 5'd31; rpt = 1;
    for (int i = 0; i < 8; i++) begin
      check("r033_bit", {31'd0, outp}, {31'd0, word[i]});
      tick();
    end
    check("r033_done", {31'd0, done}, 32'd1);
    load = 0;
    tick();
    check("r033_ready", {31'd0, ready}, 32'd1);

    // Reset mid-pattern, then restart
    data = word; len = 5'd31; rpt = 0; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 7; i++) tick();
    check("r034_idx7", {27'd0, bit_idx}, 32'd7);
    rst = 1; load = 1; stop = 1;
    tick();
    check("r034_ready", {31'd0, ready}, 32'd1);
    check("r034_valid", {31'd0, out_valid}, 32'd0);
    check("r034_idx",   {27'd0, bit_idx}, 32'd0);
    check("r034_outp",  {31'd0, outp}, 32'd0);
    rst = 0; stop = 0; data = 32'h000000A5; len = 5'd3; load = 1;
    tick();
    load = 0;
    check("r034_restart_idx", {27'd0, bit_idx}, 32'd0);
    check("r034_restart_bit", {31'd0, outp}, 32'd1);
    stop = 1; tick(); stop = 0;

    // load+stop in IDLE starts; stop at last bit beats completion
    data = word; len = 5'd3; rpt = 0; load = 1; stop = 1;
    tick();
    load = 0; stop = 0;
    check("r035_start", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) tick();
    check("r035_last", {27'd0, bit_idx}, 32'd3);
    stop = 1;
    tick();
    stop = 0;
    check("r035_ready", {31'd0, ready}, 32'd1);
    check("r035_no_done", {31'd0, done}, 32'd0);
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 23) == 0);
      rpt  = ($urandom_range(0, 3) == 0);
      data = $urandom;
      len  = (($urandom_range(0, 1) == 0) ? IW'($urandom_range(0, 5)) : IW'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
